sr_cmd_encoder: RTL and testbench

SR_CMD_ENCODER -- requirements
Module: sr_cmd_encoder

---
 rtl/sr_cmd_encoder.sv | 180 ++++++++++++++++++
 tb/tb_sr_cmd_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_encoder.sv
// sr_cmd_encoder
// ---------------------------------------------------------------------------
// Converts a target bit vector into a serial train of set/reset command
// pulses for a bank of WIDTH external SR flip-flops. The block keeps a
// shadow copy of the flip-flop state. It walks the channels from 0 to
// WIDTH-1 and pulses s_out[i] or r_out[i] for PULSE_CYCLES clocks only on
// channels whose target differs from the shadow.
//
// Optional feature (macro SR_CMD_VERIFY_EN): adds the q_in read-back port
// and a sticky mismatch flag. In the DONE cycle, q_in is compared against
// the shadow.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   tgt_valid  target vector offered
//   tgt_ready  target can be accepted this cycle (IDLE and no clr)
//   tgt_data   desired flip-flop value per channel
//   clr        request to drive every channel to 0 (wins over tgt_valid)
//   s_out      registered per-channel set command
//   r_out      registered per-channel reset command
//   shadow     recorded flip-flop state
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse at the end of a command sequence
//   q_in       flip-flop read-back            (SR_CMD_VERIFY_EN only)
//   mismatch   sticky read-back error flag    (SR_CMD_VERIFY_EN only)
// ---------------------------------------------------------------------------
module sr_cmd_encoder #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             clr,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] shadow,
    output logic             busy,
    output logic             done
`ifdef SR_CMD_VERIFY_EN
    ,
    input  logic [WIDTH-1:0] q_in,
    output logic             mismatch
`endif
);

    // The index must be able to reach WIDTH, which marks the end of the scan.
    localparam int IW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] target, target_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shadow_n;
    logic [WIDTH-1:0] s_n, r_n;
    logic [WIDTH-1:0] sel;
    logic             last_pulse;

    // One-hot select of the current channel. It is all-zero once idx
    // reaches WIDTH, because the bit shifts out of range.
    assign sel        = WIDTH'(1) << idx;
    assign last_pulse = (cnt == CW'(PULSE_CYCLES - 1));

    assign tgt_ready  = (state == IDLE) && !clr;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_comb begin
        // NOTE: every signal written here gets a default first. A path
        // that left one unassigned would infer a latch.
        state_n  = state;
        target_n = target;
        idx_n    = idx;
        cnt_n    = cnt;
        shadow_n = shadow;
        s_n      = '0;
        r_n      = '0;

        case (state)
            IDLE: begin
                if (clr) begin
                    target_n = '0;
                    idx_n    = '0;
                    state_n  = SCAN;
                end else if (tgt_valid) begin
                    target_n = tgt_data;
                    idx_n    = '0;
                    state_n  = SCAN;
                end
            end

            SCAN: begin
                if (idx == IW'(WIDTH)) begin
                    state_n = DONE;
                end else if (((target ^ shadow) & sel) == '0) begin
                    idx_n = idx + IW'(1);
                end else begin
                    // The command is registered, so it rises together with
                    // the PULSE state and lasts exactly as long as that state.
                    state_n = PULSE;
                    cnt_n   = '0;
                    s_n     = target & sel;
                    r_n     = ~target & sel;
                end
            end

            PULSE: begin
                if (last_pulse) begin
                    shadow_n = (shadow & ~sel) | (target & sel);
                    idx_n    = idx + IW'(1);
                    state_n  = SCAN;
                end else begin
                    cnt_n = cnt + CW'(1);
                    s_n   = s_out;
                    r_n   = r_out;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            target <= '0;
            idx    <= '0;
            cnt    <= '0;
            shadow <= '0;
            s_out  <= '0;
            r_out  <= '0;
        end else begin
            // NOTE: use non-blocking assignments for every registered value.
            // Then all flops update from the same pre-edge values.
            state  <= state_n;
            target <= target_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            s_out  <= s_n;
            r_out  <= r_n;
        end
    end

`ifdef SR_CMD_VERIFY_EN
    logic accept;

    assign accept = (state == IDLE) && (clr || tgt_valid);

    // In the DONE cycle the shadow holds its final value, so the read-back
    // must agree with it. The flag stays set until the next command starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch <= 1'b0;
        end else if (accept) begin
            mismatch <= 1'b0;
        end else if ((state == DONE) && (q_in != shadow)) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_cmd_encoder.sv
module tb_sr_cmd_encoder;

    localparam int W = 8;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tgt_valid = 1'b0;
    logic         tgt_ready;
    logic [W-1:0] tgt_data = '0;
    logic         clr = 1'b0;
    logic [W-1:0] s_out, r_out, shadow;
    logic         busy, done;
`ifdef SR_CMD_VERIFY_EN
    logic [W-1:0] q_in = '0;
    logic         mismatch;
    logic         m_mm = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sr_cmd_encoder #(.WIDTH(W), .PULSE_CYCLES(P)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .clr       (clr),
        .s_out     (s_out),
        .r_out     (r_out),
        .shadow    (shadow),
        .busy      (busy),
        .done      (done)
`ifdef SR_CMD_VERIFY_EN
        ,
        .q_in      (q_in),
        .mismatch  (mismatch)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // When a command is accepted, the model expands it into the complete list
    // of per-cycle expected outputs. It then plays that list back one clock
    // at a time.
    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] sh;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur = '0;
    logic [W-1:0] m_shadow = '0;

    task automatic build(input logic [W-1:0] tgt);
        logic [W-1:0] sh;
        logic [W-1:0] one;
        sh = m_shadow;
        for (int i = 0; i < W; i++) begin
            exp_q.push_back('{s: '0, r: '0, sh: sh, busy: 1'b1, done: 1'b0});
            if (tgt[i] != sh[i]) begin
                one = '0;
                one[i] = 1'b1;
                for (int k = 0; k < P; k++)
                    exp_q.push_back('{s: tgt[i] ? one : '0, r: tgt[i] ? '0 : one,
                                      sh: sh, busy: 1'b1, done: 1'b0});
                sh[i] = tgt[i];
            end
        end
        exp_q.push_back('{s: '0, r: '0, sh: sh, busy: 1'b1, done: 1'b0});
        exp_q.push_back('{s: '0, r: '0, sh: sh, busy: 1'b1, done: 1'b1});
        m_shadow = sh;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_shadow = '0;
            cur      = '0;
`ifdef SR_CMD_VERIFY_EN
            m_mm     = 1'b0;
`endif
        end else begin
`ifdef SR_CMD_VERIFY_EN
            if (cur.done && (q_in != cur.sh)) m_mm = 1'b1;
`endif
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else if (!cur.busy && (clr || tgt_valid)) begin
`ifdef SR_CMD_VERIFY_EN
                m_mm = 1'b0;
`endif
                build(clr ? '0 : tgt_data);
                cur = exp_q.pop_front();
            end else begin
                cur = '{s: '0, r: '0, sh: m_shadow, busy: 1'b0, done: 1'b0};
            end
        end
    end

    // Compare process: outputs are checked mid-cycle, away from the active edge.
    always @(negedge clk) begin
        check("s_out",     s_out,     cur.s);
        check("r_out",     r_out,     cur.r);
        check("shadow",    shadow,    cur.sh);
        check("busy",      busy,      cur.busy);
        check("done",      done,      cur.done);
        check("tgt_ready", tgt_ready, !cur.busy && !clr);
`ifdef SR_CMD_VERIFY_EN
        check("mismatch",  mismatch,  m_mm);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic offer(input logic [W-1:0] d);
        tgt_valid = 1'b1;
        tgt_data  = d;
        step();
        tgt_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt_a, cnt_b;
        logic [W-1:0] s_or, r_or;

        // Reset, then release.
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_ready",  tgt_ready, 1'b1);
        check("rst_s",      s_out,     '0);
        check("rst_r",      r_out,     '0);
        check("rst_shadow", shadow,    '0);
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   done,      1'b0);

        // Target 0x81 from 0x00: two set pulses of P cycles each.
        offer(8'h81);
        n = 0; cnt_a = 0; cnt_b = 0; r_or = '0;
        while (!done && n < 100) begin
            if (s_out == 8'h01) cnt_a++;
            if (s_out == 8'h80) cnt_b++;
            r_or |= r_out;
            step();
            n++;
        end
        check("lat_81",   n,     15);   // 8 + 2*3 + 1
        check("s01_len",  cnt_a, P);
        check("s80_len",  cnt_b, P);
        check("r_none",   r_or,  '0);
        check("sh_81",    shadow, 8'h81);
        wait_idle();

        // clr together with tgt_valid: clr wins, and the vector is dropped.
        clr = 1'b1; tgt_valid = 1'b1; tgt_data = 8'hFF;
        #1;
        check("clr_ready", tgt_ready, 1'b0);
        step();
        clr = 1'b0; tgt_valid = 1'b0;
        n = 0; s_or = '0; r_or = '0;
        while (!done && n < 100) begin
            s_or |= s_out;
            r_or |= r_out;
            step();
            n++;
        end
        check("clr_r_bits", r_or, 8'h81);
        check("clr_s_none", s_or, '0);
        wait_idle();
        check("clr_shadow", shadow, 8'h00);

        // Target 0x04: s_out[2] is held for P cycles. An offer made while
        // the block is busy is ignored.
        offer(8'h04);
        n = 0; cnt_a = 0;
        while (!done && n < 100) begin
            if (s_out[2]) cnt_a++;
            if (n == 3) begin tgt_valid = 1'b1; tgt_data = 8'hFF; end
            else tgt_valid = 1'b0;
            step();
            n++;
        end
        tgt_valid = 1'b0;
        check("s2_len", cnt_a, 3);
        check("lat_04", n, 12);          // 8 + 1*3 + 1
        wait_idle();
        check("sh_04", shadow, 8'h04);

        // Drop reset_n in the middle of a pulse.
        offer(~m_shadow);
        n = 0;
        while ((s_out | r_out) == '0 && n < 50) begin step(); n++; end
        check("pulse_seen", n < 50, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_s",      s_out,  '0);
        check("arst_r",      r_out,  '0);
        check("arst_shadow", shadow, '0);
        check("arst_busy",   busy,   1'b0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 500; i++) begin
            tgt_valid = ($urandom_range(0, 2) == 0);
            tgt_data  = W'($urandom);
            clr       = ($urandom_range(0, 11) == 0);
`ifdef SR_CMD_VERIFY_EN
            q_in      = ($urandom_range(0, 1) == 0) ? m_shadow : W'($urandom);
`endif
            step();
        end
        tgt_valid = 1'b0;
        clr       = 1'b0;
        wait_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
